// File: rtl/day6_col_framer.sv
// rtl/day6_col_framer.sv - ASCII column framer ahead of the Day 6 column solver
module day6_col_framer #(
    parameter int CNT_W          = 16,
    parameter int MAX_BLOCK_COLS = 4
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             load,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_eof,
    input  logic [7:0]       in_c0,
    input  logic [7:0]       in_c1,
    input  logic [7:0]       in_c2,
    input  logic [7:0]       in_c3,
    input  logic [7:0]       in_op,
    input  logic             out_ready,
    output logic             col_valid,
    output logic [3:0]       r0_digit,
    output logic [3:0]       r1_digit,
    output logic [3:0]       r2_digit,
    output logic [3:0]       r3_digit,
    output logic             r0_space,
    output logic             r1_space,
    output logic             r2_space,
    output logic             r3_space,
    output logic             block_start,
    output logic             block_plus,
    output logic             col_last,
    output logic             frame_last,
    output logic [CNT_W-1:0] blocks,
    output logic             err,
    output logic             eof_seen
);

    localparam int BW_W = $clog2(MAX_BLOCK_COLS + 2);
    localparam logic [BW_W-1:0] CNT_MAX = BW_W'(MAX_BLOCK_COLS);
    localparam logic [BW_W-1:0] CNT_SAT = BW_W'(MAX_BLOCK_COLS + 1);
    localparam logic [7:0] CH_SP   = 8'h20;
    localparam logic [7:0] CH_PLUS = 8'h2B;
    localparam logic [7:0] CH_MUL  = 8'h2A;

    logic             p_valid, p_start, p_plus, p_sepafter;
    logic [3:0][3:0]  p_digit;
    logic [3:0]       p_space;
    logic [BW_W-1:0]  p_cnt;

    logic             o_valid, o_start, o_plus, o_last, o_frame_last;
    logic [3:0][3:0]  o_digit;
    logic [3:0]       o_space;

    logic [3:0][7:0]  rows;
    logic [3:0][3:0]  dec_digit;
    logic [3:0]       dec_space;
    logic             digit_bad, op_bad, width_bad, is_sep;
    logic             new_start, new_plus;
    logic [BW_W-1:0]  new_cnt;
    logic             take_data, take_sep, take_eof, move_p, consume;

    assign rows = {in_c3, in_c2, in_c1, in_c0};

    always_comb begin
        digit_bad = 1'b0;
        dec_digit = '0;
        dec_space = '0;
        for (int i = 0; i < 4; i++) begin
            if (rows[i] >= 8'h30 && rows[i] <= 8'h39) begin
                dec_digit[i] = rows[i][3:0];
            end else begin
                dec_space[i] = 1'b1;
                if (rows[i] != CH_SP) digit_bad = 1'b1;
            end
        end
    end

    assign is_sep = (in_c0 == CH_SP) && (in_c1 == CH_SP) && (in_c2 == CH_SP) &&
                    (in_c3 == CH_SP) && (in_op == CH_SP);

    // A column opens a block when nothing is pending (first since load) or a separator followed P.
    assign new_start = ~p_valid | p_sepafter;
    assign new_plus  = new_start ? (in_op == CH_PLUS) : p_plus;
    assign op_bad    = new_start ? ((in_op != CH_PLUS) && (in_op != CH_MUL)) : (in_op != CH_SP);
    assign new_cnt   = new_start ? BW_W'(1) : ((p_cnt == CNT_SAT) ? p_cnt : p_cnt + BW_W'(1));
    assign width_bad = new_cnt > CNT_MAX;

    assign in_ready  = ~eof_seen & ~load &
                       (~p_valid | (~in_eof & is_sep) | ~o_valid | out_ready);
    assign take_data = in_valid & in_ready & ~in_eof & ~is_sep;
    assign take_sep  = in_valid & in_ready & ~in_eof & is_sep;
    assign take_eof  = in_valid & in_ready & in_eof;
    assign move_p    = (take_data | take_eof) & p_valid;
    assign consume   = o_valid & out_ready;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            p_valid <= 1'b0; p_start <= 1'b0; p_plus <= 1'b0; p_sepafter <= 1'b0;
            p_digit <= '0; p_space <= '0; p_cnt <= '0;
            o_valid <= 1'b0; o_start <= 1'b0; o_plus <= 1'b0; o_last <= 1'b0;
            o_frame_last <= 1'b0; o_digit <= '0; o_space <= '0;
            blocks <= '0; err <= 1'b0; eof_seen <= 1'b0;
        end else if (load) begin
            p_valid <= 1'b0; p_start <= 1'b0; p_plus <= 1'b0; p_sepafter <= 1'b0;
            p_digit <= '0; p_space <= '0; p_cnt <= '0;
            o_valid <= 1'b0; o_start <= 1'b0; o_plus <= 1'b0; o_last <= 1'b0;
            o_frame_last <= 1'b0; o_digit <= '0; o_space <= '0;
            blocks <= '0; eof_seen <= 1'b0;
        end else begin
            if (consume) begin
                o_valid <= 1'b0;
                if (o_last) blocks <= blocks + CNT_W'(1);
            end
            if (move_p) begin
                o_valid      <= 1'b1;
                o_start      <= p_start;
                o_plus       <= p_plus;
                o_digit      <= p_digit;
                o_space      <= p_space;
                o_last       <= take_eof | p_sepafter;
                o_frame_last <= take_eof;
            end
            if (take_data) begin
                p_valid    <= 1'b1;
                p_start    <= new_start;
                p_plus     <= new_plus;
                p_sepafter <= 1'b0;
                p_digit    <= dec_digit;
                p_space    <= dec_space;
                p_cnt      <= new_cnt;
                if (digit_bad | op_bad | width_bad) err <= 1'b1;
            end
            if (take_sep && p_valid) p_sepafter <= 1'b1;
            if (take_eof) begin
                eof_seen   <= 1'b1;
                p_valid    <= 1'b0;
                p_sepafter <= 1'b0;
                if (!p_valid) err <= 1'b1;
            end
        end
    end

    assign col_valid   = o_valid;
    assign block_start = o_start;
    assign block_plus  = o_plus;
    assign col_last    = o_last;
    assign frame_last  = o_frame_last;
    assign r0_digit    = o_digit[0];
    assign r1_digit    = o_digit[1];
    assign r2_digit    = o_digit[2];
    assign r3_digit    = o_digit[3];
    assign r0_space    = o_space[0];
    assign r1_space    = o_space[1];
    assign r2_space    = o_space[2];
    assign r3_space    = o_space[3];

endmodule

// File: tb/tb_day6_col_framer.sv
// tb/tb_day6_col_framer.sv - directed bench for day6_col_framer
module tb_day6_col_framer;

    logic        clock = 1'b0;
    logic        clear_n, load, in_valid, in_eof, out_ready;
    logic [7:0]  in_c0, in_c1, in_c2, in_c3, in_op;
    logic        in_ready, col_valid;
    logic [3:0]  r0_digit, r1_digit, r2_digit, r3_digit;
    logic        r0_space, r1_space, r2_space, r3_space;
    logic        block_start, block_plus, col_last, frame_last, err, eof_seen;
    logic [15:0] blocks;

    int n_checks = 0;
    int n_fail   = 0;
    logic [23:0] obs[$];

    localparam logic [31:0] SEP = 32'h20202020;

    day6_col_framer #(.CNT_W(16), .MAX_BLOCK_COLS(4)) dut (
        .clock(clock), .clear_n(clear_n), .load(load),
        .in_valid(in_valid), .in_ready(in_ready), .in_eof(in_eof),
        .in_c0(in_c0), .in_c1(in_c1), .in_c2(in_c2), .in_c3(in_c3), .in_op(in_op),
        .out_ready(out_ready), .col_valid(col_valid),
        .r0_digit(r0_digit), .r1_digit(r1_digit), .r2_digit(r2_digit), .r3_digit(r3_digit),
        .r0_space(r0_space), .r1_space(r1_space), .r2_space(r2_space), .r3_space(r3_space),
        .block_start(block_start), .block_plus(block_plus), .col_last(col_last),
        .frame_last(frame_last), .blocks(blocks), .err(err), .eof_seen(eof_seen)
    );

    always #5 clock = ~clock;

    // {start, plus, last, frame_last, r0..r3 digits, r0..r3 spaces}
    always @(negedge clock)
        if (clear_n && col_valid && out_ready)
            obs.push_back({block_start, block_plus, col_last, frame_last,
                           r0_digit, r1_digit, r2_digit, r3_digit,
                           r0_space, r1_space, r2_space, r3_space});

    function automatic logic [23:0] colv(input logic st, input logic pl, input logic la,
                                         input logic fl, input logic [15:0] dg,
                                         input logic [3:0] sp);
        return {st, pl, la, fl, dg, sp};
    endfunction

    task automatic present(input logic eof, input logic [31:0] s, input logic [7:0] op);
        in_valid = 1'b1; in_eof = eof; in_op = op;
        in_c0 = s[31:24]; in_c1 = s[23:16]; in_c2 = s[15:8]; in_c3 = s[7:0];
    endtask

    task automatic send(input logic eof, input logic [31:0] s, input logic [7:0] op);
        int w;
        present(eof, s, op);
        w = 0;
        @(negedge clock);
        while (!in_ready && w < 50) begin
            w++;
            @(negedge clock);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL send_timeout in_ready=%b required 1", in_ready);
            n_fail++;
        end
        @(posedge clock); #1;
        in_valid = 1'b0; in_eof = 1'b0;
    endtask

    task automatic do_reset;
        clear_n = 1'b0; #2; clear_n = 1'b1;
        @(posedge clock); #1;
        obs.delete();
    endtask

    task automatic drain;
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        clear_n = 1'b0; load = 1'b0; in_valid = 1'b0; in_eof = 1'b0; out_ready = 1'b0;
        in_c0 = 8'h20; in_c1 = 8'h20; in_c2 = 8'h20; in_c3 = 8'h20; in_op = 8'h20;
        #3;
        n_checks++;
        if ({col_valid, block_start, block_plus, col_last, frame_last, err, eof_seen, blocks,
             r0_digit, r1_digit, r2_digit, r3_digit, r0_space, r1_space, r2_space, r3_space} !== '0
            || in_ready !== 1'b1) begin
            $display("FAIL reset_state col_valid=%b err=%b blocks=%0d in_ready=%b required all 0, in_ready 1",
                     col_valid, err, blocks, in_ready);
            n_fail++;
        end
        @(posedge clock); #1;
        clear_n = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_two_block;
        logic [23:0] exp [3];
        exp[0] = colv(1, 0, 0, 0, 16'h1234, 4'b0000);
        exp[1] = colv(0, 0, 1, 0, 16'h5000, 4'b0111);
        exp[2] = colv(1, 1, 1, 1, 16'h7800, 4'b0011);
        do_reset();
        out_ready = 1'b1;
        send(0, "1234", "*");
        send(0, "5   ", " ");
        @(negedge clock);
        n_checks++;
        if (col_valid !== 1'b1 || r3_digit !== 4'd4) begin
            $display("FAIL two_block_latency col_valid=%b r3_digit=%0d required 1,4", col_valid, r3_digit);
            n_fail++;
        end
        @(posedge clock); #1;
        send(0, SEP, " ");
        send(0, "78  ", "+");
        send(1, 32'h0, " ");
        @(negedge clock);
        n_checks++;
        if (col_valid !== 1'b1 || frame_last !== 1'b1) begin
            $display("FAIL two_block_eof_latency col_valid=%b frame_last=%b required 1,1", col_valid, frame_last);
            n_fail++;
        end
        drain();
        n_checks++;
        if (obs.size() != 3) begin
            $display("FAIL two_block_count got=%0d required 3", obs.size());
            n_fail++;
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs[i] !== exp[i]) begin
                    $display("FAIL two_block_col%0d got=%h required %h", i, obs[i], exp[i]);
                    n_fail++;
                end
            end
        end
        n_checks++;
        if (blocks !== 16'd2 || err !== 1'b0 || eof_seen !== 1'b1) begin
            $display("FAIL two_block_status blocks=%0d err=%b eof_seen=%b required 2,0,1", blocks, err, eof_seen);
            n_fail++;
        end
    endtask

    task automatic test_backpressure;
        logic [23:0] exp [3];
        exp[0] = colv(1, 0, 0, 0, 16'h1234, 4'b0000);
        exp[1] = colv(0, 0, 1, 0, 16'h5000, 4'b0111);
        exp[2] = colv(1, 1, 1, 1, 16'h7800, 4'b0011);
        do_reset();
        out_ready = 1'b1;
        send(0, "1234", "*");
        send(0, "5   ", " ");
        out_ready = 1'b0;
        send(0, SEP, " ");
        present(0, "78  ", "+");
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            n_checks++;
            if (col_valid !== 1'b1 || r0_digit !== 4'd1 || block_start !== 1'b1 || in_ready !== 1'b0) begin
                $display("FAIL backpressure_hold%0d col_valid=%b r0=%0d start=%b in_ready=%b required 1,1,1,0",
                         i, col_valid, r0_digit, block_start, in_ready);
                n_fail++;
            end
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
        send(0, "78  ", "+");
        send(1, 32'h0, " ");
        drain();
        n_checks++;
        if (obs.size() != 3) begin
            $display("FAIL backpressure_count got=%0d required 3", obs.size());
            n_fail++;
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (obs[i] !== exp[i]) begin
                    $display("FAIL backpressure_col%0d got=%h required %h", i, obs[i], exp[i]);
                    n_fail++;
                end
            end
        end
        n_checks++;
        if (blocks !== 16'd2) begin
            $display("FAIL backpressure_blocks got=%0d required 2", blocks);
            n_fail++;
        end
    endtask

    task automatic test_separators;
        do_reset();
        out_ready = 1'b1;
        send(0, SEP, " ");
        send(0, SEP, " ");
        send(0, "9   ", "+");
        send(0, SEP, " ");
        send(0, SEP, " ");
        send(1, 32'h0, " ");
        drain();
        n_checks++;
        if (obs.size() != 1 || obs[0] !== colv(1, 1, 1, 1, 16'h9000, 4'b0111)) begin
            $display("FAIL separators_col n=%0d got=%h required 1 x %h", obs.size(),
                     (obs.size() > 0) ? obs[0] : 24'h0, colv(1, 1, 1, 1, 16'h9000, 4'b0111));
            n_fail++;
        end
        n_checks++;
        if (blocks !== 16'd1 || err !== 1'b0) begin
            $display("FAIL separators_status blocks=%0d err=%b required 1,0", blocks, err);
            n_fail++;
        end
    endtask

    task automatic test_bad_op;
        do_reset();
        out_ready = 1'b1;
        send(0, "1   ", "x");
        send(1, 32'h0, " ");
        drain();
        n_checks++;
        if (err !== 1'b1 || obs.size() != 1 || obs[0] !== colv(1, 0, 1, 1, 16'h1000, 4'b0111)) begin
            $display("FAIL bad_op err=%b n=%0d required err 1, one col %h", err, obs.size(),
                     colv(1, 0, 1, 1, 16'h1000, 4'b0111));
            n_fail++;
        end
    endtask

    task automatic test_bare_eof;
        do_reset();
        out_ready = 1'b1;
        n_checks++;
        if (err !== 1'b0) begin
            $display("FAIL bare_eof_pre err=%b required 0", err);
            n_fail++;
        end
        send(1, 32'h0, " ");
        drain();
        n_checks++;
        if (err !== 1'b1 || eof_seen !== 1'b1 || obs.size() != 0 || blocks !== 16'd0) begin
            $display("FAIL bare_eof err=%b eof_seen=%b cols=%0d blocks=%0d required 1,1,0,0",
                     err, eof_seen, obs.size(), blocks);
            n_fail++;
        end
    endtask

    task automatic test_wide_block;
        logic [31:0] d [5];
        d[0] = "1   "; d[1] = "2   "; d[2] = "3   "; d[3] = "4   "; d[4] = "5   ";
        do_reset();
        out_ready = 1'b1;
        send(0, d[0], "+");
        for (int i = 1; i < 4; i++) send(0, d[i], " ");
        n_checks++;
        if (err !== 1'b0) begin
            $display("FAIL wide_block_four err=%b required 0", err);
            n_fail++;
        end
        send(0, d[4], " ");
        n_checks++;
        if (err !== 1'b1) begin
            $display("FAIL wide_block_five err=%b required 1", err);
            n_fail++;
        end
        send(1, 32'h0, " ");
        drain();
        n_checks++;
        if (obs.size() != 5) begin
            $display("FAIL wide_block_count got=%0d required 5", obs.size());
            n_fail++;
        end else begin
            for (int i = 0; i < 5; i++) begin
                logic [23:0] e;
                e = colv(i == 0, 1, i == 4, i == 4, {4'(i + 1), 12'h000}, 4'b0111);
                n_checks++;
                if (obs[i] !== e) begin
                    $display("FAIL wide_block_col%0d got=%h required %h", i, obs[i], e);
                    n_fail++;
                end
            end
        end
    endtask

    task automatic test_reset_midframe;
        do_reset();
        out_ready = 1'b0;
        send(0, "1234", "*");
        send(0, "5   ", " ");
        clear_n = 1'b0;
        #1;
        n_checks++;
        if (col_valid !== 1'b0 || r0_digit !== 4'd0 || block_start !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL reset_midframe col_valid=%b r0=%0d start=%b in_ready=%b required 0,0,0,1",
                     col_valid, r0_digit, block_start, in_ready);
            n_fail++;
        end
        #1; clear_n = 1'b1;
        @(posedge clock); #1;
        obs.delete();
        out_ready = 1'b1;
        send(0, "9   ", "+");
        send(1, 32'h0, " ");
        drain();
        n_checks++;
        if (obs.size() != 1 || obs[0] !== colv(1, 1, 1, 1, 16'h9000, 4'b0111)) begin
            $display("FAIL reset_midframe_after n=%0d required 1 x %h", obs.size(),
                     colv(1, 1, 1, 1, 16'h9000, 4'b0111));
            n_fail++;
        end
    endtask

    task automatic test_load;
        do_reset();
        out_ready = 1'b1;
        send(0, "1   ", "*");
        send(1, 32'h0, " ");
        drain();
        present(0, "2   ", "*");
        @(negedge clock);
        n_checks++;
        if (eof_seen !== 1'b1 || blocks !== 16'd1 || in_ready !== 1'b0) begin
            $display("FAIL load_pre eof_seen=%b blocks=%0d in_ready=%b required 1,1,0", eof_seen, blocks, in_ready);
            n_fail++;
        end
        load = 1'b1;
        @(posedge clock); #1;
        load = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (eof_seen !== 1'b0 || blocks !== 16'd0 || col_valid !== 1'b0) begin
            $display("FAIL load_clear eof_seen=%b blocks=%0d col_valid=%b required 0,0,0", eof_seen, blocks, col_valid);
            n_fail++;
        end
        obs.delete();
        send(0, "3   ", "*");
        send(1, 32'h0, " ");
        drain();
        n_checks++;
        if (obs.size() != 1 || obs[0] !== colv(1, 0, 1, 1, 16'h3000, 4'b0111) || blocks !== 16'd1) begin
            $display("FAIL load_new_frame n=%0d blocks=%0d required 1 x %h, blocks 1", obs.size(), blocks,
                     colv(1, 0, 1, 1, 16'h3000, 4'b0111));
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_two_block();
        test_backpressure();
        test_separators();
        test_bad_op();
        test_bare_eof();
        test_wide_block();
        test_reset_midframe();
        test_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
